// File: rtl/req_ack_pkg.sv
// Shared definitions for the toggle-encoded request/acknowledge responder:
// FSM state encoding, data-width default and a timer-width helper.
package req_ack_pkg;

    // Default request word width.
    localparam int DATA_W_DEFAULT = 16;

    // Fixed 2-bit state encoding. It is exposed as plain localparams so that
    // other code can decode a raw 2-bit state value without the enum type.
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_WAIT_ENC = 2'd1;
    localparam logic [1:0] ST_ACK_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,  // no request outstanding
        ST_WAIT = ST_WAIT_ENC,  // request issued, waiting for i_done or timeout
        ST_ACK  = ST_ACK_ENC    // ack toggle just inverted, one turnaround cycle
    } state_t;

    // Width of the wait timer. The counter must hold 0..timeout-1, and a
    // disabled timeout (0) still needs one bit so the vector stays legal.
    function automatic int timer_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage : req_ack_pkg

// File: rtl/toggle_edge_sync.sv
// Brings an asynchronous request toggle into the local clock domain and turns
// each level change into a one-cycle registered edge pulse. Edges are
// suppressed while the synchroniser refills after reset, so a toggle level
// that was already high at reset is adopted without creating a request.
module toggle_edge_sync #(
    parameter int SYNC_STAGES = 2   // synchroniser depth, must be >= 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_toggle,
    output logic o_edge
);

    // The window covers the synchroniser stages plus the history flop, which
    // is exactly how long a reset-time level takes to reach the history flop.
    localparam int ARM_CYCLES = SYNC_STAGES + 1;
    localparam int ARM_W      = $clog2(ARM_CYCLES + 1);
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(ARM_CYCLES);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [ARM_W-1:0]       r_arm_cnt;
    logic                   r_edge;

    logic w_sync_out;
    logic w_armed;
    logic w_edge_raw;

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_armed    = (r_arm_cnt == ARM_DONE);
    assign w_edge_raw = w_sync_out ^ r_hist;

    // Multi-flop synchroniser: shift the raw toggle through SYNC_STAGES flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            // NOTE: non-blocking assignment is what makes this a shift register;
            // each stage must take the previous stage's value from before the edge.
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_toggle};
        end
    end

    // History flop: remembers the last synchronised level, always tracking,
    // so any level present during the arming window is absorbed silently.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist <= 1'b0;
        end else begin
            r_hist <= w_sync_out;
        end
    end

    // Arming counter: counts up once after reset and then parks at ARM_DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_arm_cnt <= '0;
        end else if (!w_armed) begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
        end
    end

    // Registered edge pulse, gated by the arming window.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_edge <= 1'b0;
        end else begin
            r_edge <= w_armed & w_edge_raw;
        end
    end

    assign o_edge = r_edge;

endmodule : toggle_edge_sync

// File: rtl/req_ack_responder.sv
// Destination side of a toggle request/acknowledge handshake. A synchronised
// request toggle edge captures the request word and issues a one-cycle
// o_req_valid pulse; completion (i_done) or an optional timeout returns an
// acknowledge toggle. Request edges arriving while a request is outstanding
// are protocol violations: they raise a sticky error and are dropped.
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT, // request word width
    parameter int SYNC_STAGES = 2,              // synchroniser depth (>= 2)
    parameter int TIMEOUT     = 1023            // max wait cycles, 0 = never
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // Initiator side (asynchronous to i_clk)
    input  logic              i_req_toggle,
    input  logic [DATA_W-1:0] i_req_data,
    output logic              o_ack_toggle,
    // Local consumer side
    output logic              o_req_valid,
    output logic [DATA_W-1:0] o_req_data,
    input  logic              i_done,
    // Status
    output logic              o_busy,
    output logic              o_timeout,
    output logic              o_err,
    input  logic              i_err_clr
);

    localparam int TMR_W  = timer_width(TIMEOUT);
    localparam bit TMO_EN = (TIMEOUT != 0);
    // Expiry value; when the timeout is disabled the comparison is never used.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMO_EN ? TIMEOUT - 1 : 0);

    state_t              r_state;
    logic [TMR_W-1:0]    r_timer;
    logic [DATA_W-1:0]   r_req_data;
    logic                r_req_valid;
    logic                r_ack_toggle;
    logic                r_timeout;
    logic                r_err;

    logic                w_edge;
    logic                w_tmr_expired;

    // Request-toggle synchroniser and edge detector.
    toggle_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_toggle (i_req_toggle),
        .o_edge   (w_edge)
    );

    // The timer sits at TIMEOUT-1 during the TIMEOUT-th cycle of WAIT
    // (the o_req_valid cycle being the first), so expiry is acted on at the
    // edge that closes that cycle.
    assign w_tmr_expired = TMO_EN && (r_timer == TMR_LAST);

    // Handshake FSM with registered data capture, pulses and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_timer      <= '0;
            r_req_data   <= '0;
            r_req_valid  <= 1'b0;
            r_ack_toggle <= 1'b0;
            r_timeout    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Pulses default low each cycle; the branches below raise them
            // for exactly the one cycle that needs them.
            r_req_valid <= 1'b0;
            r_timeout   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // i_done is meaningless here and deliberately ignored.
                    if (w_edge) begin
                        r_state     <= ST_WAIT;
                        r_req_data  <= i_req_data;
                        r_req_valid <= 1'b1;
                        r_timer     <= '0;
                    end
                end

                ST_WAIT: begin
                    // Completion takes priority over a coincident expiry.
                    if (i_done) begin
                        r_state      <= ST_ACK;
                        r_ack_toggle <= ~r_ack_toggle;
                    end else if (w_tmr_expired) begin
                        r_state      <= ST_ACK;
                        r_ack_toggle <= ~r_ack_toggle;
                        r_timeout    <= 1'b1;
                    end else if (TMO_EN) begin
                        // Expiry leaves WAIT before the counter can wrap.
                        r_timer <= r_timer + 1'b1;
                    end
                end

                ST_ACK: begin
                    // Turnaround cycle; i_done is ignored here as well.
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A request edge while busy breaks the initiator's contract. The
            // edge is consumed (the FSM above only acts on it in IDLE) and
            // flagged; a new violation outranks a same-cycle clear.
            if (w_edge && (r_state != ST_IDLE)) begin
                r_err <= 1'b1;
            end else if (i_err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign o_req_valid  = r_req_valid;
    assign o_req_data   = r_req_data;
    assign o_ack_toggle = r_ack_toggle;
    assign o_timeout    = r_timeout;
    assign o_err        = r_err;
    assign o_busy       = (r_state != ST_IDLE);

endmodule : req_ack_responder

// File: tb/tb_req_ack_responder.sv
// Self-checking bench for req_ack_responder (TIMEOUT reduced to 8).
// Inputs change 1 time unit after a rising edge and outputs are checked at
// the same point, so each check sees the result of the preceding edge.
module tb_req_ack_responder;

    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 8;

    logic              i_clk;
    logic              i_rst;
    logic              i_req_toggle;
    logic [DATA_W-1:0] i_req_data;
    logic              o_ack_toggle;
    logic              o_req_valid;
    logic [DATA_W-1:0] o_req_data;
    logic              i_done;
    logic              o_busy;
    logic              o_timeout;
    logic              o_err;
    logic              i_err_clr;

    req_ack_responder #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (2),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_toggle (i_req_toggle),
        .i_req_data   (i_req_data),
        .o_ack_toggle (o_ack_toggle),
        .o_req_valid  (o_req_valid),
        .o_req_data   (o_req_data),
        .i_done       (i_done),
        .o_busy       (o_busy),
        .o_timeout    (o_timeout),
        .o_err        (o_err),
        .i_err_clr    (i_err_clr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Monitor counting request pulses and acknowledge inversions.
    int   mon_valid    = 0;
    int   mon_ack      = 0;
    logic mon_prev_ack = 1'b0;
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_req_valid) mon_valid <= mon_valid + 1;
            if (o_ack_toggle !== mon_prev_ack) mon_ack <= mon_ack + 1;
        end
        mon_prev_ack <= o_ack_toggle;
    end

    // Per-cycle vector: inputs applied, one clock, then expected outputs.
    typedef struct {
        logic              tog;
        logic [DATA_W-1:0] din;
        logic              done;
        logic              clr;
        logic              valid;
        logic [DATA_W-1:0] dout;
        logic              busy;
        logic              ack;
        logic              tmo;
        logic              err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic tog, input logic [DATA_W-1:0] din,
                                input logic done, input logic clr,
                                input logic valid, input logic [DATA_W-1:0] dout,
                                input logic busy, input logic ack,
                                input logic tmo, input logic err);
        vec_t v;
        v.tog = tog; v.din = din; v.done = done; v.clr = clr;
        v.valid = valid; v.dout = dout; v.busy = busy; v.ack = ack;
        v.tmo = tmo; v.err = err;
        vecs.push_back(v);
    endfunction

    logic [DATA_W-1:0] b2b_data;
    logic              b2b_tog;
    logic              exp_ack;
    bit                seen;
    int                dly;
    int                base_valid;
    int                base_ack;

    // Global guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst        = 1'b1;
        i_req_toggle = 1'b1;
        i_req_data   = '0;
        i_done       = 1'b0;
        i_err_clr    = 1'b0;

        // ---------- reset with toggle already high ----------
        repeat (3) tick();
        check("rst_valid", o_req_valid, 1'b0);
        check("rst_data",  o_req_data,  16'h0000);
        check("rst_ack",   o_ack_toggle, 1'b0);
        check("rst_busy",  o_busy,      1'b0);
        check("rst_tmo",   o_timeout,   1'b0);
        check("rst_err",   o_err,       1'b0);
        i_rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("arm%0d_valid", c), o_req_valid, 1'b0);
            check($sformatf("arm%0d_err", c),   o_err,       1'b0);
            check($sformatf("arm%0d_ack", c),   o_ack_toggle, 1'b0);
        end

        // ---------- table: handshake, timeout, done at expiry, idle done ----------
        // Handshake: toggle 1->0, valid 4 edges after the drive (3 after sampling),
        // i_done two cycles after valid, busy for 4 cycles.
        for (int k = 0; k < 3; k++) add(0, 16'hA5C3, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
        add(0, 16'hA5C3, 0, 0, 1, 16'hA5C3, 1, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 16'hA5C3, 1, 0, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 16'hA5C3, 1, 0, 0, 0);
        add(0, 16'h0000, 1, 0, 0, 16'hA5C3, 1, 1, 0, 0);
        add(0, 16'h0000, 0, 0, 0, 16'hA5C3, 0, 1, 0, 0);
        // Timeout: no i_done, o_timeout and ack inversion 8 edges after valid.
        for (int k = 0; k < 3; k++) add(1, 16'h1234, 0, 0, 0, 16'hA5C3, 0, 1, 0, 0);
        add(1, 16'h1234, 0, 0, 1, 16'h1234, 1, 1, 0, 0);
        for (int k = 0; k < 7; k++) add(1, 16'h1234, 0, 0, 0, 16'h1234, 1, 1, 0, 0);
        add(1, 16'h1234, 0, 0, 0, 16'h1234, 1, 0, 1, 0);
        add(1, 16'h1234, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
        // i_done coincides with timer expiry: ack inverts, no timeout pulse.
        for (int k = 0; k < 3; k++) add(0, 16'hBEEF, 0, 0, 0, 16'h1234, 0, 0, 0, 0);
        add(0, 16'hBEEF, 0, 0, 1, 16'hBEEF, 1, 0, 0, 0);
        for (int k = 0; k < 7; k++) add(0, 16'hBEEF, 0, 0, 0, 16'hBEEF, 1, 0, 0, 0);
        add(0, 16'hBEEF, 1, 0, 0, 16'hBEEF, 1, 1, 0, 0);
        add(0, 16'hBEEF, 0, 0, 0, 16'hBEEF, 0, 1, 0, 0);
        // i_done while idle is ignored.
        add(0, 16'hBEEF, 1, 0, 0, 16'hBEEF, 0, 1, 0, 0);
        add(0, 16'hBEEF, 0, 0, 0, 16'hBEEF, 0, 1, 0, 0);

        foreach (vecs[k]) begin
            i_req_toggle = vecs[k].tog;
            i_req_data   = vecs[k].din;
            i_done       = vecs[k].done;
            i_err_clr    = vecs[k].clr;
            tick();
            check($sformatf("vec%0d_valid", k), o_req_valid,  vecs[k].valid);
            check($sformatf("vec%0d_data", k),  o_req_data,   vecs[k].dout);
            check($sformatf("vec%0d_busy", k),  o_busy,       vecs[k].busy);
            check($sformatf("vec%0d_ack", k),   o_ack_toggle, vecs[k].ack);
            check($sformatf("vec%0d_tmo", k),   o_timeout,    vecs[k].tmo);
            check($sformatf("vec%0d_err", k),   o_err,        vecs[k].err);
        end
        i_done = 1'b0;

        // ---------- violation: second toggle while WAIT ----------
        i_req_toggle = 1'b1;
        i_req_data   = 16'h0E01;
        repeat (4) tick();
        check("viol1_first_valid", o_req_valid, 1'b1);
        i_req_toggle = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            check($sformatf("viol1_no_valid_c%0d", c), o_req_valid, 1'b0);
        end
        check("viol1_err_set", o_err,  1'b1);
        check("viol1_busy",    o_busy, 1'b1);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check("viol1_ack", o_ack_toggle, 1'b0);
        tick();
        check("viol1_idle", o_busy, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("viol1_consumed_c%0d", c), o_req_valid, 1'b0);
        end
        check("viol1_err_sticky", o_err, 1'b1);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("viol1_err_cleared", o_err, 1'b0);

        // ---------- violation coinciding with i_err_clr ----------
        i_req_toggle = 1'b1;
        i_req_data   = 16'h0E02;
        repeat (4) tick();
        check("viol2_first_valid", o_req_valid, 1'b1);
        i_req_toggle = 1'b0;
        repeat (3) tick();
        check("viol2_err_before", o_err, 1'b0);
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("viol2_set_beats_clr", o_err, 1'b1);
        i_done = 1'b1;
        tick();
        i_done = 1'b0;
        check("viol2_ack", o_ack_toggle, 1'b1);
        tick();
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        check("viol2_err_cleared", o_err, 1'b0);

        // ---------- 20 back-to-back requests ----------
        repeat (2) tick();
        base_valid = mon_valid;
        base_ack   = mon_ack;
        b2b_tog    = 1'b0;
        exp_ack    = 1'b1;
        for (int r = 0; r < 20; r++) begin
            b2b_data     = 16'($urandom);
            b2b_tog      = ~b2b_tog;
            i_req_toggle = b2b_tog;
            i_req_data   = b2b_data;
            seen = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                tick();
                if (o_req_valid) seen = 1'b1;
            end
            check($sformatf("b2b%0d_valid_seen", r), seen, 1'b1);
            check($sformatf("b2b%0d_data", r), o_req_data, b2b_data);
            dly = $urandom_range(0, 5);
            repeat (dly) tick();
            i_done = 1'b1;
            tick();
            i_done = 1'b0;
            exp_ack = ~exp_ack;
            check($sformatf("b2b%0d_ack", r), o_ack_toggle, exp_ack);
        end
        repeat (3) tick();
        check("b2b_valid_count", mon_valid - base_valid, 20);
        check("b2b_ack_count",   mon_ack - base_ack,     20);
        check("b2b_err",         o_err,                  1'b0);
        check("b2b_idle",        o_busy,                 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_req_ack_responder
